// File: rtl/q_dot_acc.sv
// q_dot_acc: sequential fixed-point dot-product accumulator.
// Streams (a, b) pairs over valid/ready, multiplies each pair through q_mul,
// and sums the products in a widened accumulator. One result is emitted per
// vector, closed either by in_last or by reaching MAX_LEN beats.
// FIXED_WIDTH and SCALE_FACTOR normally come from include.vh; the defaults
// below apply when that header has not already defined them.
// Optional feature macro: Q_ACC_SAT_EN. When defined, the result is clamped to
// the FIXED_WIDTH signed range and out_ovf flags the clamp. When undefined,
// the result wraps and out_ovf is tied to 0.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif

// q_mul: combinational signed Q-format multiply. The full product is shifted
// right by the fraction width and truncated back to W bits.
module q_mul #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  logic signed [2*W-1:0] full;

  // Full-precision product, then rescale back to the Q format.
  always_comb begin
    full = a * b;
    y    = W'(full >>> FRAC);
  end
endmodule

module q_dot_acc #(
  parameter int ACC_GUARD = 8,
  parameter int MAX_LEN   = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [`FIXED_WIDTH-1:0]  in_a,
  input  logic signed [`FIXED_WIDTH-1:0]  in_b,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [`FIXED_WIDTH-1:0]         out_data,
  output logic [$clog2(MAX_LEN+1)-1:0]    out_count,
  output logic                            out_ovf,
  output logic                            out_len_err
);
  localparam int W     = `FIXED_WIDTH;
  localparam int FRAC  = $clog2(`SCALE_FACTOR);
  localparam int ACC_W = W + ACC_GUARD;
  localparam int CW    = $clog2(MAX_LEN + 1);

  // The guard bits must cover MAX_LEN worst-case products so acc never wraps.
  if (MAX_LEN > (2 ** ACC_GUARD)) begin : g_len_check
    $error("q_dot_acc: MAX_LEN must not exceed 2**ACC_GUARD");
  end
  if (MAX_LEN < 1) begin : g_len_min_check
    $error("q_dot_acc: MAX_LEN must be at least 1");
  end

  // Handshake semantics: a beat transfers on a rising edge where
  // in_valid && in_ready; a result transfers where out_valid && out_ready.
  // in_ready and out_valid depend only on the FSM state, never on the
  // partner's valid/ready in the same cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // state is kept as a plainly named register so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_next;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic signed [W-1:0]     prod;
  logic                    beat;
  logic                    close;
  logic                    handshake;
  logic [W-1:0]            data_res;

  q_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .a (in_a),
    .b (in_b),
    .y (prod)
  );

  assign in_ready   = (state != OUTPUT);
  assign out_valid  = (state == OUTPUT);
  assign beat       = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign sum_next   = acc + {{ACC_GUARD{prod[W-1]}}, prod};
  assign count_next = count + CW'(1);
  // The MAX_LEN-th beat closes the vector even without in_last.
  assign close      = beat && (in_last || (count_next == CW'(MAX_LEN)));

`ifdef Q_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_GUARD+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_GUARD+1){1'b1}}, {(W-1){1'b0}}};
  logic ovf_res;

  // Clamp the widened sum into the signed FIXED_WIDTH range.
  always_comb begin
    data_res = sum_next[W-1:0];
    ovf_res  = 1'b0;
    if (sum_next > SAT_MAX) begin
      data_res = {1'b0, {(W-1){1'b1}}};
      ovf_res  = 1'b1;
    end else if (sum_next < SAT_MIN) begin
      data_res = {1'b1, {(W-1){1'b0}}};
      ovf_res  = 1'b1;
    end
  end

  // Overflow flag is captured alongside the result on vector close.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (close) begin
      out_ovf <= ovf_res;
    end
  end
`else
  assign data_res = sum_next[W-1:0];
  assign out_ovf  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accumulate until close, hold result until taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (close) begin
          state_next = OUTPUT;
        end else if (beat) begin
          state_next = ACCUM;
        end
      end
      OUTPUT: begin
        if (handshake) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, beat counter and registered result fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      count       <= '0;
      out_data    <= '0;
      out_count   <= '0;
      out_len_err <= 1'b0;
    end else begin
      if (handshake) begin
        acc   <= '0;
        count <= '0;
      end else if (beat) begin
        acc   <= sum_next;
        count <= count_next;
      end
      if (close) begin
        out_data    <= data_res;
        out_count   <= count_next;
        out_len_err <= !in_last;
      end
    end
  end
endmodule

// File: tb/tb_q_dot_acc.sv
// tb_q_dot_acc: directed bench for q_dot_acc. Each task exercises one
// scenario with hand-computed expectations; a summary line ends the run.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif

module tb_q_dot_acc;
  localparam int W         = `FIXED_WIDTH;
  localparam int S         = `SCALE_FACTOR;
  localparam int ACC_GUARD = 8;
  localparam int MAX_LEN   = 256;
  localparam int CW        = $clog2(MAX_LEN + 1);

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_a;
  logic signed [W-1:0] in_b;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [CW-1:0]       out_count;
  logic                out_ovf;
  logic                out_len_err;

  int total;
  int bad;

  q_dot_acc #(.ACC_GUARD(ACC_GUARD), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_ovf     (out_ovf),
    .out_len_err (out_len_err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present one beat and advance one clock; sampling is at +1.
  task automatic send_beat(input int a, input int b, input logic last);
    in_a     = W'(a);
    in_b     = W'(b);
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Driver: accept the pending result with a one-cycle out_ready pulse.
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({out_valid, out_data, out_count, out_ovf, out_len_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%0b data=%0d count=%0d ovf=%0b len_err=%0b exp all 0",
               out_valid, out_data, out_count, out_ovf, out_len_err);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_single_beat();
    in_a = W'(S/2); in_b = W'(S/4); in_last = 1'b1; in_valid = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_valid_early got=%0b exp=0", out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_valid got=%0b exp=1", out_valid);
    end
    total++;
    if (out_data !== W'(S/8)) begin
      bad++;
      $display("FAIL single_data got=%0d exp=%0d", $signed(out_data), S/8);
    end
    total++;
    if ({out_count, out_ovf, out_len_err, in_ready} !== {CW'(1), 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_flags got count=%0d ovf=%0b len_err=%0b in_ready=%0b exp 1/0/0/0",
               out_count, out_ovf, out_len_err, in_ready);
    end
    take_result();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL single_after_take got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_four_beats();
    for (int i = 0; i < 3; i++) send_beat(S/2, S/2, 1'b0);
    send_beat(S/2, S/2, 1'b1);
    total++;
    if ({out_valid, out_data, out_count, out_len_err} !== {1'b1, W'(S), CW'(4), 1'b0}) begin
      bad++;
      $display("FAIL four_beats got valid=%0b data=%0d count=%0d len_err=%0b exp 1/%0d/4/0",
               out_valid, $signed(out_data), out_count, out_len_err, S);
    end
    take_result();
  endtask

  task automatic test_mixed_signs();
    send_beat(S/2, S/4, 1'b0);
    send_beat(S/2, -S/4, 1'b0);
    send_beat(-S/2, -S/4, 1'b1);
    total++;
    if ({out_valid, out_data, out_count} !== {1'b1, W'(S/8), CW'(3)}) begin
      bad++;
      $display("FAIL mixed_signs got valid=%0b data=%0d count=%0d exp 1/%0d/3",
               out_valid, $signed(out_data), out_count, S/8);
    end
    take_result();
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_data;
    logic         exp_ovf;
`ifdef Q_ACC_SAT_EN
    exp_data = W'((2 ** (W-1)) - 1);
    exp_ovf  = 1'b1;
`else
    exp_data = W'(-(2 ** (W-2)));
    exp_ovf  = 1'b0;
`endif
    for (int i = 0; i < 2; i++) send_beat(2 ** (W-2), S, 1'b0);
    send_beat(2 ** (W-2), S, 1'b1);
    total++;
    if (out_data !== exp_data) begin
      bad++;
      $display("FAIL overflow_data got=%0d exp=%0d", $signed(out_data), $signed(exp_data));
    end
    total++;
    if ({out_ovf, out_count} !== {exp_ovf, CW'(3)}) begin
      bad++;
      $display("FAIL overflow_flag got ovf=%0b count=%0d exp %0b/3", out_ovf, out_count, exp_ovf);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    send_beat(S/4, S/4, 1'b0);
    send_beat(S/4, S/4, 1'b1);
    // Offer the next vector's beat while the result is held.
    in_a = W'(S/4); in_b = W'(S/4); in_last = 1'b1; in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, W'(S/8), CW'(2)}) begin
        bad++;
        $display("FAIL backpressure_hold cycle=%0d got valid=%0b in_ready=%0b data=%0d count=%0d exp 1/0/%0d/2",
                 i, out_valid, in_ready, $signed(out_data), out_count, S/8);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL backpressure_release got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if ({out_valid, out_data, out_count} !== {1'b1, W'(S/16), CW'(1)}) begin
      bad++;
      $display("FAIL backpressure_next got valid=%0b data=%0d count=%0d exp 1/%0d/1",
               out_valid, $signed(out_data), out_count, S/16);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    send_beat(S/2, S/2, 1'b0);
    send_beat(S/2, S/2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_state got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    send_beat(S/4, S/4, 1'b1);
    total++;
    if ({out_valid, out_data, out_count} !== {1'b1, W'(S/16), CW'(1)}) begin
      bad++;
      $display("FAIL reset_mid_result got valid=%0b data=%0d count=%0d exp 1/%0d/1",
               out_valid, $signed(out_data), out_count, S/16);
    end
    // Reset while a result is held must drop it and zero the outputs.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, out_data, out_count, out_ovf, out_len_err} !== {1'b0, 1'b1, {(W+CW+2){1'b0}}}) begin
      bad++;
      $display("FAIL reset_in_output got valid=%0b in_ready=%0b data=%0d count=%0d ovf=%0b len_err=%0b exp 0/1/0/0/0/0",
               out_valid, in_ready, out_data, out_count, out_ovf, out_len_err);
    end
  endtask

  task automatic test_len_err();
    for (int i = 0; i < MAX_LEN - 1; i++) send_beat(S/4, S/4, 1'b0);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL len_err_early got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    send_beat(S/4, S/4, 1'b0);
    total++;
    if ({out_valid, out_len_err, out_count} !== {1'b1, 1'b1, CW'(MAX_LEN)}) begin
      bad++;
      $display("FAIL len_err_close got valid=%0b len_err=%0b count=%0d exp 1/1/%0d",
               out_valid, out_len_err, out_count, MAX_LEN);
    end
    total++;
    if (out_data !== W'((S/16) * MAX_LEN)) begin
      bad++;
      $display("FAIL len_err_data got=%0d exp=%0d", $signed(out_data), (S/16) * MAX_LEN);
    end
    take_result();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL len_err_after_take got valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_beat();
    test_four_beats();
    test_mixed_signs();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_len_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
